// File: rtl/sum_offset_unit.sv
// Per-channel (A+B) minus a shared running offset, with a 1-deep valid/ready output register.
// Define SUM_OFFSET_UNIT_SAT_EN to compile saturating mode (MODE=1); otherwise MODE is ignored and results wrap.
module sum_offset_unit #(
   parameter int NBITS = 8,
   parameter int NCH   = 4,
   parameter int STEP  = 1
) (
   input  logic                 CLK,
   input  logic                 RST_N,
   input  logic [NCH*NBITS-1:0] A,
   input  logic [NCH*NBITS-1:0] B,
   input  logic                 IN_VALID,
   output logic                 IN_READY,
   input  logic                 MODE,
   output logic [NCH*NBITS-1:0] XOUT,
   output logic                 OUT_VALID,
   input  logic                 OUT_READY,
   output logic [NBITS-1:0]     OFFSET
);

`ifdef SUM_OFFSET_UNIT_SAT_EN
   localparam bit SAT_EN = 1'b1;
`else
   localparam bit SAT_EN = 1'b0;
`endif

   localparam logic [NBITS-1:0] STEP_W = NBITS'(STEP);

   logic [NBITS-1:0]     cnt_q, cnt_d, cnt_n;
   logic [NCH*NBITS-1:0] xout_q, xout_d, res;
   logic                 vld_q, vld_d;
   logic                 accept;

   assign IN_READY  = !vld_q || OUT_READY;
   assign accept    = IN_VALID && IN_READY;
   assign cnt_n     = cnt_q + STEP_W;
   assign XOUT      = xout_q;
   assign OUT_VALID = vld_q;
   assign OFFSET    = cnt_q;

   // Difference carries one extra bit for sign and one for the sum carry.
   always_comb begin
      logic [NBITS:0]          sum;
      logic signed [NBITS+1:0] diff;
      sum  = '0;
      diff = '0;
      res  = '0;
      for (int unsigned c = 0; c < NCH; c++) begin
         sum  = {1'b0, A[c*NBITS +: NBITS]} + {1'b0, B[c*NBITS +: NBITS]};
         diff = $signed({1'b0, sum}) - $signed({2'b00, cnt_n});
         if (SAT_EN && MODE) begin
            if (diff < 0)
               res[c*NBITS +: NBITS] = '0;
            else if (diff > $signed({2'b00, {NBITS{1'b1}}}))
               res[c*NBITS +: NBITS] = '1;
            else
               res[c*NBITS +: NBITS] = diff[NBITS-1:0];
         end else begin
            res[c*NBITS +: NBITS] = diff[NBITS-1:0];
         end
      end
   end

   always_comb begin
      cnt_d  = cnt_q;
      xout_d = xout_q;
      vld_d  = vld_q;
      if (accept) begin
         cnt_d  = cnt_n;
         xout_d = res;
         vld_d  = 1'b1;
      end else if (OUT_READY) begin
         vld_d  = 1'b0;
      end
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         cnt_q  <= '0;
         xout_q <= '0;
         vld_q  <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         xout_q <= xout_d;
         vld_q  <= vld_d;
      end
   end

endmodule

// File: tb/tb_sum_offset_unit.sv
// Directed bench for sum_offset_unit (NBITS=8, NCH=2, STEP=1); expectations follow SUM_OFFSET_UNIT_SAT_EN.
module tb_sum_offset_unit;

   logic        CLK = 1'b0;
   logic        RST_N;
   logic [15:0] A, B, XOUT;
   logic        IN_VALID, IN_READY, MODE, OUT_VALID, OUT_READY;
   logic [7:0]  OFFSET;

   int total = 0;
   int bad   = 0;

`ifdef SUM_OFFSET_UNIT_SAT_EN
   localparam bit SAT = 1'b1;
`else
   localparam bit SAT = 1'b0;
`endif

   sum_offset_unit #(.NBITS(8), .NCH(2), .STEP(1)) dut (
      .CLK(CLK), .RST_N(RST_N), .A(A), .B(B), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
      .MODE(MODE), .XOUT(XOUT), .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY), .OFFSET(OFFSET)
   );

   always #5 CLK = ~CLK;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic [7:0] a1, input logic [7:0] a0, input logic [7:0] b1,
                        input logic [7:0] b0, input logic m, input logic v);
      A = {a1, a0};
      B = {b1, b0};
      MODE = m;
      IN_VALID = v;
   endtask

   task automatic do_reset();
      RST_N = 1'b0;
      IN_VALID = 1'b0;
      repeat (2) @(negedge CLK);
      RST_N = 1'b1;
   endtask

   initial begin
      RST_N = 1'b0;
      OUT_READY = 1'b1;
      drive(0, 0, 0, 0, 0, 0);
      @(negedge CLK);
      #1;
      check_eq("rst_valid",  OUT_VALID, 0);
      check_eq("rst_xout",   XOUT, 0);
      check_eq("rst_offset", OFFSET, 0);
      check_eq("rst_ready",  IN_READY, 1);
      // No accept may occur while reset is asserted, even with IN_VALID high.
      drive(1, 1, 1, 1, 0, 1);
      @(negedge CLK);
      check_eq("rst_hold_offset", OFFSET, 0);
      check_eq("rst_hold_valid",  OUT_VALID, 0);
      IN_VALID = 1'b0;
      RST_N = 1'b1;

      // Basic accept, cnt_n = 1
      @(negedge CLK);
      drive(10, 10, 5, 5, 0, 1);
      @(negedge CLK);
      check_eq("basic_valid",  OUT_VALID, 1);
      check_eq("basic_xout",   XOUT, {8'd14, 8'd14});
      check_eq("basic_offset", OFFSET, 1);

      // Backpressure for 3 cycles
      drive(20, 20, 20, 20, 0, 1);
      OUT_READY = 1'b0;
      #1;
      check_eq("bp_ready0", IN_READY, 0);
      for (int i = 0; i < 3; i++) begin
         @(negedge CLK);
         check_eq("bp_ready",  IN_READY, 0);
         check_eq("bp_valid",  OUT_VALID, 1);
         check_eq("bp_xout",   XOUT, {8'd14, 8'd14});
         check_eq("bp_offset", OFFSET, 1);
      end
      OUT_READY = 1'b1;
      #1;
      check_eq("bp_release_ready", IN_READY, 1);
      @(negedge CLK);
      check_eq("bp_resume_xout",   XOUT, {8'd38, 8'd38});
      check_eq("bp_resume_offset", OFFSET, 2);

      // Streaming: a=i, b=2i, cnt_n=3+i -> xout = 2i-3 mod 256
      for (int i = 0; i < 10; i++) begin
         drive(8'(i), 8'(i), 8'(2*i), 8'(2*i), 0, 1);
         @(negedge CLK);
         check_eq("stream_valid",  OUT_VALID, 1);
         check_eq("stream_offset", OFFSET, 32'(3 + i));
         check_eq("stream_xout",   XOUT, {8'(2*i - 3), 8'(2*i - 3)});
      end

      // Drain without accept
      IN_VALID = 1'b0;
      @(negedge CLK);
      check_eq("drain_valid",  OUT_VALID, 0);
      check_eq("drain_offset", OFFSET, 12);

      // Asynchronous reset mid-cycle while a result is pending
      drive(3, 3, 2, 2, 0, 1);
      OUT_READY = 1'b0;
      @(negedge CLK);
      check_eq("pre_arst_valid", OUT_VALID, 1);
      IN_VALID = 1'b0;
      @(posedge CLK);
      #2;
      RST_N = 1'b0;
      #1;
      check_eq("arst_valid",  OUT_VALID, 0);
      check_eq("arst_xout",   XOUT, 0);
      check_eq("arst_offset", OFFSET, 0);
      @(negedge CLK);
      RST_N = 1'b1;
      OUT_READY = 1'b1;
      drive(3, 3, 3, 3, 0, 1);
      @(negedge CLK);
      check_eq("post_arst_xout",   XOUT, {8'd5, 8'd5});
      check_eq("post_arst_offset", OFFSET, 1);

      // Counter wrap: 255 accepts of zeros, then one more
      do_reset();
      drive(0, 0, 0, 0, 0, 1);
      repeat (255) @(negedge CLK);
      check_eq("wrap255_offset", OFFSET, 255);
      check_eq("wrap255_xout",   XOUT, {8'd1, 8'd1});
      @(negedge CLK);
      check_eq("wrap0_offset", OFFSET, 0);
      check_eq("wrap0_xout",   XOUT, 0);

      // Saturate mode (wraps when the feature is compiled out)
      do_reset();
      drive(0, 0, 0, 0, 1, 1);
      @(negedge CLK);
      check_eq("sat_low_xout", XOUT, SAT ? 32'd0 : {8'd255, 8'd255});
      drive(200, 200, 100, 100, 1, 1);
      @(negedge CLK);
      check_eq("sat_high_xout",   XOUT, SAT ? {8'd255, 8'd255} : {8'd42, 8'd42});
      check_eq("sat_high_offset", OFFSET, 2);
      drive(50, 7, 1, 0, 1, 1);
      @(negedge CLK);
      check_eq("sat_inrange_xout", XOUT, {8'd48, 8'd4});
      // Channel independence in wrap mode: ch1 = 50+1-4, ch0 = 2+0-4
      drive(50, 2, 1, 0, 0, 1);
      @(negedge CLK);
      check_eq("chan_xout", XOUT, {8'd47, 8'd254});
      IN_VALID = 1'b0;
      @(negedge CLK);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/sum_offset_unit.md
SUM_OFFSET_UNIT -- requirements
Module: sum_offset_unit

Interface
REQ-001 SHALL have parameter NBITS, default 8, data width per channel (>= 2).
REQ-002 SHALL have parameter NCH, default 4, number of parallel channels (>= 1).
REQ-003 SHALL have parameter STEP, default 1, offset counter increment per accepted transfer (0 <= STEP < 2**NBITS).
REQ-004 SHALL have port CLK  input  1  sole clock, rising edge.
REQ-005 SHALL have port RST_N  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port A  input  NCH*NBITS  unsigned operand A; channel c in bits [c*NBITS +: NBITS].
REQ-007 SHALL have port B  input  NCH*NBITS  unsigned operand B, same packing as A.
REQ-008 SHALL have port IN_VALID  input  1  A/B valid.
REQ-009 SHALL have port IN_READY  output  1  unit can accept A/B this cycle.
REQ-010 SHALL have port MODE  input  1  0 = wrap, 1 = saturate; sampled on accept.
REQ-011 SHALL have port XOUT  output  NCH*NBITS  per-channel result, same packing as A.
REQ-012 SHALL have port OUT_VALID  output  1  XOUT valid.
REQ-013 SHALL have port OUT_READY  input  1  downstream accepts XOUT.
REQ-014 SHALL have port OFFSET  output  NBITS  current offset counter value.

Function
REQ-015 Accept = IN_VALID && IN_READY; drain = OUT_VALID && OUT_READY.
REQ-016 IN_READY SHALL equal !OUT_VALID || OUT_READY (combinational, no IN_VALID dependency).
REQ-017 On accept, offset counter SHALL update to cnt_n = (cnt + STEP) mod 2**NBITS; counter SHALL NOT change without accept.
REQ-018 On accept, each channel SHALL register XOUT[c] = (A[c] + B[c]) - cnt_n, using the updated counter; latency exactly 1 cycle.
REQ-019 Sum SHALL be formed in NBITS+1 bits, difference in NBITS+2 bits signed; channels fully independent, one counter shared by all channels.
REQ-020 Wrap mode: XOUT[c] SHALL be the difference truncated to NBITS (mod 2**NBITS).
REQ-021 Saturate mode: XOUT[c] SHALL clamp to 0 if difference < 0, to 2**NBITS-1 if > 2**NBITS-1.
REQ-022 OUT_VALID SHALL set on accept; clear on drain without accept; stay 1 on simultaneous drain and accept (new result replaces old, no bubble).
REQ-023 While OUT_VALID && !OUT_READY, XOUT, OUT_VALID and counter SHALL hold stable.
REQ-024 OFFSET SHALL reflect the registered counter (equals cnt_n used by the XOUT currently presented after each accept).
REQ-025 Counter wrap from 2**NBITS-1 SHALL proceed modulo 2**NBITS with no flag or stall.

Reset
REQ-026 RST_N low SHALL asynchronously force counter = 0, OFFSET = 0, XOUT = 0, OUT_VALID = 0.
REQ-027 Reset mid-operation SHALL discard any pending result; no transfer SHALL be accepted while RST_N is low (IN_READY reflects OUT_VALID = 0 only after release takes effect; inputs ignored during reset).
REQ-028 First accept after reset release SHALL use cnt_n = STEP.

Configuration
REQ-029 Macro SUM_OFFSET_UNIT_SAT_EN: when defined, saturate logic SHALL be compiled and MODE honoured per REQ-021.
REQ-030 When SUM_OFFSET_UNIT_SAT_EN is undefined, MODE port SHALL remain but be ignored; all results SHALL use wrap mode.

Verification (NBITS=8, NCH=2, STEP=1, SAT_EN defined unless stated)
REQ-031 Reset, then accept A=10,B=5 both channels, MODE=0 -> next cycle OUT_VALID=1, XOUT=14 both channels, OFFSET=1.
REQ-032 OUT_READY=0 for 3 cycles, IN_VALID=1 -> IN_READY=0, XOUT and OFFSET unchanged; then OUT_READY=1 -> accept resumes with no bubble.
REQ-033 Drive 255 accepts (OFFSET=255), accept A=B=0 MODE=0 -> OFFSET=0, XOUT=0; prior accept at cnt_n=255 with A=B=0 -> XOUT=1.
REQ-034 MODE=1: A=0,B=0 at cnt_n=1 -> XOUT=0; A=200,B=100 at cnt_n=2 -> XOUT=255; repeat with macro undefined -> XOUT=255 and 42.
REQ-035 OUT_VALID=1 and RST_N pulsed low mid-cycle -> OUT_VALID, XOUT, OFFSET go 0 immediately without clock edge; next accept uses cnt_n=1.
REQ-036 OUT_VALID=1, OUT_READY=1, IN_VALID=1 every cycle for 10 cycles -> one result per cycle, OUT_VALID never drops, OFFSET advances by 1 per cycle.
